control_sequencer: RTL and testbench

//  Hardwired control unit for the Phase-1 datapath. Steps fetch (T0-T2) and execute (T3-T5) phases.

---
 rtl/cpu_ctrl_pkg.sv | 53 +++++
 rtl/ctrl_decode.sv | 19 +
 rtl/control_sequencer.sv | 179 +++++++++++++++++
 tb/tb_control_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the Phase-1 hardwired control sequencer:
// FSM states, control-vector bit positions, opcode constants and IR field helpers.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T1W,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5
    } state_t;

    typedef logic [4:0] opcode_t;
    typedef logic [3:0] reg_idx_t;

    // Register-load enables; general registers R0-R15 occupy bits [15:0].
    localparam int EN_PC_IN  = 20;
    localparam int EN_MDR_IN = 21;
    localparam int EN_IR_IN  = 23;
    localparam int EN_Z_IN   = 24;
    localparam int EN_MAR_IN = 25;
    localparam int EN_Y_IN   = 27;
    localparam int EN_INC_PC = 28;

    // Bus drivers; general registers R0-R15 occupy bits [15:0].
    localparam int BS_ZLO_OUT = 19;
    localparam int BS_PC_OUT  = 20;
    localparam int BS_MDR_OUT = 21;

    localparam opcode_t OP_NEG     = 5'd5;
    localparam opcode_t OP_NOT     = 5'd6;
    localparam opcode_t OP_ALU_MAX = 5'd15;

    function automatic opcode_t ir_opcode(input logic [31:0] ir);
        return ir[31:27];
    endfunction

    function automatic reg_idx_t ir_ra(input logic [31:0] ir);
        return ir[26:23];
    endfunction

    function automatic reg_idx_t ir_rb(input logic [31:0] ir);
        return ir[22:19];
    endfunction

    function automatic reg_idx_t ir_rc(input logic [31:0] ir);
        return ir[18:15];
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: ALU function, unary/binary shape and
// undefined-opcode detection for the execute phase.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [3:0] alu_op,
    output logic       is_unary,
    output logic       is_illegal
);

    always_comb begin
        is_illegal = (opcode > OP_ALU_MAX);
        // Undefined opcodes never reach the ALU, so keep its function code quiet.
        alu_op     = is_illegal ? 4'd0 : opcode[3:0];
        is_unary   = !is_illegal && ((opcode == OP_NEG) || (opcode == OP_NOT));
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit for the Phase-1 datapath: one FSM state per
// clock, control outputs decoded from the state register, the IR and (in T1W) mem_rdy.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int N_CTRL      = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               run,
    input  logic [31:0]        ir,
    input  logic               mem_rdy,
    output logic [N_CTRL-1:0]  enable,
    output logic [N_CTRL-1:0]  bus_select,
    output logic               md_read,
    output logic [3:0]         alu_op,
    output logic               illegal,
    output logic               mem_err,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int               TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    state_t           end_state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             retire;
    logic             timeout;

    opcode_t          opcode;
    reg_idx_t         ra;
    reg_idx_t         rb;
    reg_idx_t         rc;
    logic [3:0]       dec_alu_op;
    logic             dec_unary;
    logic             dec_illegal;
    logic             unused_ir;

    assign opcode    = ir_opcode(ir);
    assign ra        = ir_ra(ir);
    assign rb        = ir_rb(ir);
    assign rc        = ir_rc(ir);
    assign unused_ir = ^ir[14:0];

    // run is only looked at here and in IDLE; mid-instruction changes are ignored.
    assign end_state = run ? ST_T0 : ST_IDLE;

    ctrl_decode u_decode (
        .opcode     (opcode),
        .alu_op     (dec_alu_op),
        .is_unary   (dec_unary),
        .is_illegal (dec_illegal)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tmo_cnt     <= '0;
            mem_err     <= 1'b0;
            instr_count <= '0;
        end else begin
            tmo_cnt <= (state_q == ST_T1W) ? tmo_cnt + TMO_W'(1) : '0;
            if (timeout) begin
                mem_err <= 1'b1;
            end
            if (retire) begin
                instr_count <= instr_count + COUNT_W'(1);
            end
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d    = state_q;
        enable     = '0;
        bus_select = '0;
        md_read    = 1'b0;
        alu_op     = 4'd0;
        illegal    = 1'b0;
        retire     = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_T0;
                end
            end

            ST_T0: begin
                bus_select[BS_PC_OUT] = 1'b1;
                enable[EN_MAR_IN]     = 1'b1;
                enable[EN_INC_PC]     = 1'b1;
                enable[EN_Z_IN]       = 1'b1;
                state_d               = ST_T1;
            end

            ST_T1: begin
                bus_select[BS_ZLO_OUT] = 1'b1;
                enable[EN_PC_IN]       = 1'b1;
                md_read                = 1'b1;
                state_d                = ST_T1W;
            end

            ST_T1W: begin
                md_read           = 1'b1;
                enable[EN_MDR_IN] = mem_rdy;
                if (mem_rdy) begin
                    state_d = ST_T2;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_T2: begin
                bus_select[BS_MDR_OUT] = 1'b1;
                enable[EN_IR_IN]       = 1'b1;
                state_d                = ST_T3;
            end

            ST_T3: begin
                if (dec_illegal) begin
                    illegal = 1'b1;
                    state_d = end_state;
                end else if (dec_unary) begin
                    bus_select[rb]  = 1'b1;
                    alu_op          = dec_alu_op;
                    enable[EN_Z_IN] = 1'b1;
                    state_d         = ST_T4;
                end else begin
                    bus_select[rb]  = 1'b1;
                    enable[EN_Y_IN] = 1'b1;
                    state_d         = ST_T4;
                end
            end

            ST_T4: begin
                if (dec_unary) begin
                    bus_select[BS_ZLO_OUT] = 1'b1;
                    enable[ra]             = 1'b1;
                    retire                 = 1'b1;
                    state_d                = end_state;
                end else begin
                    bus_select[rc]  = 1'b1;
                    alu_op          = dec_alu_op;
                    enable[EN_Z_IN] = 1'b1;
                    state_d         = ST_T5;
                end
            end

            ST_T5: begin
                bus_select[BS_ZLO_OUT] = 1'b1;
                enable[ra]             = 1'b1;
                retire                 = 1'b1;
                state_d                = end_state;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle stimulus and expected outputs are
// queued from a bench-side model of the fetch/execute sequence, then drained cycle by cycle.
module tb_control_sequencer;

    localparam int COUNT_W = 4;

    logic               clk = 1'b0;
    logic               clr;
    logic               run;
    logic [31:0]        ir;
    logic               mem_rdy;
    logic [31:0]        enable;
    logic [31:0]        bus_select;
    logic               md_read;
    logic [3:0]         alu_op;
    logic               illegal;
    logic               mem_err;
    logic [COUNT_W-1:0] instr_count;

    control_sequencer #(
        .N_CTRL      (32),
        .MEM_TIMEOUT (16),
        .COUNT_W     (COUNT_W)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .run         (run),
        .ir          (ir),
        .mem_rdy     (mem_rdy),
        .enable      (enable),
        .bus_select  (bus_select),
        .md_read     (md_read),
        .alu_op      (alu_op),
        .illegal     (illegal),
        .mem_err     (mem_err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]        enable;
        logic [31:0]        bus_select;
        logic               md_read;
        logic [3:0]         alu_op;
        logic               illegal;
        logic               mem_err;
        logic [COUNT_W-1:0] instr_count;
    } obs_t;

    typedef struct packed {
        logic        run;
        logic        mem_rdy;
        logic [31:0] ir;
    } stim_t;

    stim_t              stim_q[$];
    obs_t               exp_q[$];
    string              tag_q[$];
    int                 n_cmp = 0;
    int                 n_bad = 0;
    logic [COUNT_W-1:0] m_count;
    logic               m_err;

    function automatic logic [31:0] b(input int i);
        return 32'd1 << i;
    endfunction

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        logic [31:0] v;
        v        = '0;
        v[31:27] = op[4:0];
        v[26:23] = ra[3:0];
        v[22:19] = rb[3:0];
        v[18:15] = rc[3:0];
        return v;
    endfunction

    function automatic void push(input string tag, input logic r, input logic m, input logic [31:0] irv,
                                 input logic [31:0] en, input logic [31:0] bs, input logic md,
                                 input logic [3:0] alu, input logic ill);
        stim_t s;
        obs_t  e;
        s.run = r;
        s.mem_rdy = m;
        s.ir = irv;
        e.enable = en;
        e.bus_select = bs;
        e.md_read = md;
        e.alu_op = alu;
        e.illegal = ill;
        e.mem_err = m_err;
        e.instr_count = m_count;
        stim_q.push_back(s);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endfunction

    // IDLE (optional), T0 and T1; mem_rdy is held high where it must be ignored.
    function automatic void push_fetch_head(input string tag, input bit from_idle);
        if (from_idle) push({tag, ":idle"}, 1'b1, 1'b1, $urandom(), '0, '0, 1'b0, 4'd0, 1'b0);
        push({tag, ":t0"}, 1'b0, 1'b1, $urandom(), b(25) | b(28) | b(24), b(20), 1'b0, 4'd0, 1'b0);
        push({tag, ":t1"}, 1'b0, 1'b1, $urandom(), b(20), b(19), 1'b1, 4'd0, 1'b0);
    endfunction

    function automatic void push_fetch(input string tag, input bit from_idle, input int waits);
        push_fetch_head(tag, from_idle);
        for (int i = 0; i < waits; i++)
            push({tag, ":t1w_wait"}, 1'b0, 1'b0, $urandom(), '0, '0, 1'b1, 4'd0, 1'b0);
        push({tag, ":t1w_rdy"}, 1'b0, 1'b1, $urandom(), b(21), '0, 1'b1, 4'd0, 1'b0);
        push({tag, ":t2"}, 1'b0, 1'b1, $urandom(), b(23), b(21), 1'b0, 4'd0, 1'b0);
    endfunction

    function automatic void push_exec(input string tag, input logic [31:0] irv, input logic run_after);
        int op;
        int ra;
        int rb;
        int rc;
        op = int'(irv[31:27]);
        ra = int'(irv[26:23]);
        rb = int'(irv[22:19]);
        rc = int'(irv[18:15]);
        if (op > 15) begin
            push({tag, ":t3_ill"}, run_after, 1'b1, irv, '0, '0, 1'b0, 4'd0, 1'b1);
        end else if (op == 5 || op == 6) begin
            push({tag, ":t3_un"}, 1'b0, 1'b1, irv, b(24), b(rb), 1'b0, 4'(op), 1'b0);
            push({tag, ":t4_un"}, run_after, 1'b1, irv, b(ra), b(19), 1'b0, 4'd0, 1'b0);
            m_count = m_count + 1'b1;
        end else begin
            push({tag, ":t3_bin"}, 1'b0, 1'b1, irv, b(27), b(rb), 1'b0, 4'd0, 1'b0);
            push({tag, ":t4_bin"}, 1'b0, 1'b1, irv, b(24), b(rc), 1'b0, 4'(op), 1'b0);
            push({tag, ":t5_bin"}, run_after, 1'b1, irv, b(ra), b(19), 1'b0, 4'd0, 1'b0);
            m_count = m_count + 1'b1;
        end
    endfunction

    function automatic void push_idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            push({tag, ":idle"}, 1'b0, 1'b1, $urandom(), '0, '0, 1'b0, 4'd0, 1'b0);
    endfunction

    // Drives each queued cycle just after a rising edge and compares mid-cycle.
    task automatic drain();
        while (stim_q.size() > 0) begin
            stim_t s;
            obs_t  e;
            obs_t  o;
            string t;
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            run = s.run;
            mem_rdy = s.mem_rdy;
            ir = s.ir;
            #2;
            o = {enable, bus_select, md_read, alu_op, illegal, mem_err, instr_count};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got en=%h bs=%h md=%b alu=%0d ill=%b err=%b cnt=%0d, expected en=%h bs=%h md=%b alu=%0d ill=%b err=%b cnt=%0d",
                         t, o.enable, o.bus_select, o.md_read, o.alu_op, o.illegal, o.mem_err, o.instr_count,
                         e.enable, e.bus_select, e.md_read, e.alu_op, e.illegal, e.mem_err, e.instr_count);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        run = 1'b0;
        mem_rdy = 1'b0;
        ir = '0;
        m_count = '0;
        m_err = 1'b0;
        #1;
        n_cmp++;
        if ({enable, bus_select, md_read, alu_op, illegal, mem_err, instr_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: got en=%h bs=%h md=%b alu=%0d ill=%b err=%b cnt=%0d, expected all zero",
                     enable, bus_select, md_read, alu_op, illegal, mem_err, instr_count);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        push_idle("reset", 5);
        drain();
    endtask

    task automatic test_unary();
        push_fetch("neg", 1'b1, 0);
        push_exec("neg", 32'h28918000, 1'b0);
        push_idle("neg_after", 1);
        push_fetch("not_r0", 1'b1, 0);
        push_exec("not_r0", mk_ir(6, 0, 0, 9), 1'b0);
        push_idle("not_after", 1);
        drain();
    endtask

    task automatic test_binary();
        push_fetch("op3", 1'b1, 0);
        push_exec("op3", 32'h19918000, 1'b0);
        push_idle("op3_after", 1);
        drain();
    endtask

    task automatic test_mem_wait();
        push_fetch("wait4", 1'b1, 4);
        push_exec("wait4", mk_ir(6, 0, 0, 0), 1'b0);
        push_idle("wait4_after", 1);
        push_fetch("wait15", 1'b1, 15);
        push_exec("wait15", mk_ir(9, 2, 11, 13), 1'b0);
        push_idle("wait15_after", 1);
        drain();
    endtask

    task automatic test_back_to_back();
        push_fetch("b2b_a", 1'b1, 0);
        push_exec("b2b_a", mk_ir(15, 15, 15, 0), 1'b1);
        push_fetch("b2b_b", 1'b0, 1);
        push_exec("b2b_b", mk_ir(5, 7, 7, 3), 1'b1);
        push_fetch("b2b_c", 1'b0, 2);
        push_exec("b2b_c", mk_ir(0, 0, 9, 4), 1'b0);
        push_idle("b2b_after", 2);
        drain();
    endtask

    task automatic test_illegal();
        push_fetch("ill20", 1'b1, 0);
        push_exec("ill20", mk_ir(20, 1, 2, 3), 1'b1);
        push_fetch("ill31", 1'b0, 0);
        push_exec("ill31", mk_ir(31, 15, 15, 15), 1'b0);
        push_idle("ill_after", 2);
        drain();
    endtask

    task automatic test_count_wrap();
        for (int i = 0; i < 18; i++) begin
            logic [31:0] irv;
            irv = mk_ir($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            push_fetch("wrap", (i == 0), $urandom_range(0, 2));
            push_exec("wrap", irv, (i != 17));
        end
        push_idle("wrap_after", 1);
        drain();
    endtask

    task automatic test_mem_timeout();
        push_fetch_head("tmo", 1'b1);
        for (int i = 0; i < 16; i++)
            push("tmo:t1w_wait", 1'b0, 1'b0, $urandom(), '0, '0, 1'b1, 4'd0, 1'b0);
        m_err = 1'b1;
        push_idle("tmo_after", 3);
        push_fetch("tmo_sticky", 1'b1, 0);
        push_exec("tmo_sticky", mk_ir(1, 4, 5, 6), 1'b0);
        push_idle("tmo_sticky_after", 1);
        drain();
    endtask

    task automatic test_clr_mid();
        logic [31:0] irv;
        irv = mk_ir(2, 4, 5, 6);
        push_fetch("clr_mid", 1'b1, 0);
        push("clr_mid:t3_bin", 1'b0, 1'b1, irv, b(27), b(5), 1'b0, 4'd0, 1'b0);
        drain();
        run = 1'b1;
        mem_rdy = 1'b1;
        ir = irv;
        #1;
        n_cmp++;
        if ({enable, bus_select, alu_op} !== {b(24), b(6), 4'd2}) begin
            n_bad++;
            $display("FAIL clr_mid_t4: got en=%h bs=%h alu=%0d, expected en=%h bs=%h alu=2",
                     enable, bus_select, alu_op, b(24), b(6));
        end
        clr = 1'b1;
        #1;
        n_cmp++;
        if ({enable, bus_select, md_read, alu_op, illegal, mem_err, instr_count} !== '0) begin
            n_bad++;
            $display("FAIL clr_mid_async: got en=%h bs=%h md=%b alu=%0d ill=%b err=%b cnt=%0d, expected all zero",
                     enable, bus_select, md_read, alu_op, illegal, mem_err, instr_count);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        m_count = '0;
        m_err = 1'b0;
        push_idle("clr_recover", 2);
        push_fetch("clr_recover", 1'b1, 0);
        push_exec("clr_recover", mk_ir(5, 3, 3, 0), 1'b0);
        push_idle("clr_recover_after", 1);
        drain();
    endtask

    initial begin
        test_reset();
        test_unary();
        test_binary();
        test_mem_wait();
        test_back_to_back();
        test_illegal();
        test_count_wrap();
        test_mem_timeout();
        test_clr_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
